turn_countdown: RTL and testbench
=================================

Name: turn_countdown

Overview:
- Consumer end of the game-timer tick interface: takes the `timeUp` tick level produced by the timer block and counts a per-turn budget of seconds down to zero.
- Provides start, pause and acknowledge control, a binary seconds count, and a BCD tens/ones pair for the 7-segment driver.
- Raises a sticky `expired` flag that the game FSM uses to forfeit the turn.

Parameters:
- START_SECS, 15, seconds loaded on start/reload; legal range 0..99.
- WIDTH, 7, width of secs_left; must satisfy 2^WIDTH > START_SECS.
- WARN_SECS, 5, low-time threshold, used only when TURN_WARN_EN is defined.

Ports:
- C_50Mhz  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- timeUp  input  1  tick level from the timer; may stay high for many cycles; one rising edge = one second.
- start  input  1  single-cycle pulse: load START_SECS and run.
- pause  input  1  level: while high, counting is frozen.
- ack  input  1  single-cycle pulse: clear expired, return to IDLE.
- secs_left  output  WIDTH  remaining seconds, binary.
- tens  output  4  BCD tens digit of secs_left.
- ones  output  4  BCD ones digit of secs_left.
- running  output  1  high in RUN state only.
- expired  output  1  sticky time-out flag, high in EXPIRED state.
- warn  output  1  low-time indicator; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; secs_left = START_SECS.
  - tick_d = 0; running = 0; expired = 0; warn = 0.
  - Reset mid-count abandons the count with no expired pulse.
- Tick detect: tick_d registers timeUp every cycle; tick = timeUp & ~tick_d. A level held high yields exactly one tick.
- States:
  - IDLE: start -> RUN, secs_left <= START_SECS. Ticks ignored.
  - RUN: evaluated in this priority order:
    - start -> reload START_SECS, stay RUN; a same-cycle tick is dropped.
    - Else secs_left == 0 -> EXPIRED. This covers START_SECS = 0: EXPIRED one cycle after start.
    - Else pause -> PAUSED; a same-cycle tick is dropped.
    - Else tick -> secs_left <= secs_left - 1. If secs_left was 1, state <= EXPIRED in the same edge, so secs_left = 0 and expired = 1 are visible together.
  - PAUSED:
    - start -> RUN with reload.
    - Else pause low -> RUN.
    - Ticks ignored; secs_left held.
  - EXPIRED:
    - secs_left held at 0.
    - start -> RUN with reload, expired cleared.
    - Else ack -> IDLE, secs_left <= START_SECS.
    - Ticks ignored; pause ignored.
- ack outside EXPIRED: no effect.
- Arithmetic: secs_left never decrements below 0 (no wrap to 2^WIDTH-1).
- BCD decode:
  - Combinational from secs_left, valid in the same cycle: tens = secs_left / 10, ones = secs_left % 10.
  - Values above 99 are unreachable by construction.
- Output timing: running and expired are registered state decodes and change on the clock edge of the state transition. Latency from the timeUp rising edge to the secs_left update is 1 clock.

Optional Feature:
- Macro: TURN_WARN_EN.
- Defined: warn = 1 when state is RUN or PAUSED and 0 < secs_left <= WARN_SECS; 0 otherwise. Registered, so it updates on the same edge as secs_left.
- Not defined: warn tied to 0; WARN_SECS unused; no extra logic.

Test Plan:
- Reset, then start, then 15 timeUp pulses each held high 100 cycles:
  - secs_left steps 15 -> 0, one decrement per pulse.
  - expired = 1 and running = 0 on the edge after the 15th rising edge; tens/ones read 1/5 before the first pulse.
- Run to secs_left = 9, raise pause, send 3 timeUp pulses, drop pause, send 1 pulse: secs_left stays 9 while paused, then becomes 8.
- start and a timeUp rising edge in the same cycle at secs_left = 4: secs_left = 15 and state RUN; the tick is not counted.
- In EXPIRED:
  - send timeUp pulses: secs_left stays 0.
  - pulse ack: state IDLE, secs_left = 15, expired = 0.
  - a second ack has no effect.
- Assert rst_n low mid-count at secs_left = 7 between clock edges: outputs go to reset values immediately without waiting for a clock edge; expired never asserted.
- With TURN_WARN_EN defined:
  - warn rises on the edge where secs_left becomes 5 and stays high through 1.
  - warn is 0 at secs_left = 0 in EXPIRED.
  - Without the macro, warn stays 0 throughout.

Source files
------------

// File: rtl/turn_countdown_if.sv
// Tick/control bundle between the game timer, the game FSM and the turn countdown.
// The master drives timeUp/start/pause/ack; the slave (turn_countdown) returns the count and status.
`timescale 1ns/1ps
interface turn_countdown_if #(
    parameter int WIDTH = 7
);
    logic             timeUp;
    logic             start;
    logic             pause;
    logic             ack;
    logic [WIDTH-1:0] secs_left;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic             running;
    logic             expired;
    logic             warn;

    modport master (
        output timeUp, start, pause, ack,
        input  secs_left, tens, ones, running, expired, warn
    );

    modport slave (
        input  timeUp, start, pause, ack,
        output secs_left, tens, ones, running, expired, warn
    );
endinterface

// File: rtl/turn_countdown.sv
// Per-turn seconds countdown driven by the timer's timeUp level, with BCD digits and a sticky expired flag.
// Optional low-time warning output is built only when TURN_WARN_EN is defined.
`timescale 1ns/1ps
module turn_countdown #(
    parameter int START_SECS = 15,
    parameter int WIDTH      = 7,
    parameter int WARN_SECS  = 5
) (
    input  logic               C_50Mhz,
    input  logic               rst_n,
    turn_countdown_if.slave    bus
);
    localparam logic [WIDTH-1:0] START_V = WIDTH'(START_SECS);
    localparam bit PARAMS_OK = (START_SECS >= 0) && (START_SECS <= 99) &&
                               (START_SECS < (2 ** WIDTH)) &&
                               (WARN_SECS >= 0) && (WARN_SECS <= 99);

    // An illegal parameter set refers to a module that does not exist, stopping elaboration.
    if (!PARAMS_OK) begin : g_illegal_params
        turn_countdown_illegal_parameters u_stop ();
    end

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] secs_q, secs_n;
    logic             tick_d;
    logic             tick;
    logic             running_q;
    logic             expired_q;
    logic [7:0]       bcd;

    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? v : v - WIDTH'(1);
    endfunction

    function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
        return {4'(int'(v) / 10), 4'(int'(v) % 10)};
    endfunction

    assign tick = bus.timeUp & ~tick_d;

    always_comb begin
        state_n = state;
        secs_n  = secs_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                    secs_n  = START_V;
                end
            end
            RUN: begin
                if (bus.start) begin
                    secs_n = START_V;
                end else if (secs_q == '0) begin
                    state_n = EXPIRED;
                end else if (bus.pause) begin
                    state_n = PAUSED;
                end else if (tick) begin
                    secs_n = sat_dec(secs_q);
                    // Reaching zero flags expiry on the same edge as the last decrement.
                    if (secs_q == WIDTH'(1)) state_n = EXPIRED;
                end
            end
            PAUSED: begin
                if (bus.start) begin
                    state_n = RUN;
                    secs_n  = START_V;
                end else if (!bus.pause) begin
                    state_n = RUN;
                end
            end
            EXPIRED: begin
                secs_n = '0;
                if (bus.start) begin
                    state_n = RUN;
                    secs_n  = START_V;
                end else if (bus.ack) begin
                    state_n = IDLE;
                    secs_n  = START_V;
                end
            end
            default: begin
                state_n = IDLE;
                secs_n  = START_V;
            end
        endcase
    end

    always_ff @(posedge C_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            secs_q    <= START_V;
            tick_d    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state     <= state_n;
            secs_q    <= secs_n;
            tick_d    <= bus.timeUp;
            running_q <= (state_n == RUN);
            expired_q <= (state_n == EXPIRED);
        end
    end

`ifdef TURN_WARN_EN
    localparam logic [WIDTH-1:0] WARN_V = WIDTH'(WARN_SECS);
    logic warn_q;

    always_ff @(posedge C_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= ((state_n == RUN) || (state_n == PAUSED)) &&
                      (secs_n != '0) && (secs_n <= WARN_V);
        end
    end

    assign bus.warn = warn_q;
`else
    assign bus.warn = 1'b0;
`endif

    assign bcd           = to_bcd(secs_q);
    assign bus.tens      = bcd[7:4];
    assign bus.ones      = bcd[3:0];
    assign bus.secs_left = secs_q;
    assign bus.running   = running_q;
    assign bus.expired   = expired_q;
endmodule

// File: tb/tb_turn_countdown.sv
// Scoreboard bench for turn_countdown: a driver pushes model predictions per cycle, a monitor pops and compares.
`timescale 1ns/1ps
module tb_turn_countdown;
    localparam int START = 15;
    localparam int WARNS = 5;
    localparam int W     = 7;

    typedef struct {
        int secs;
        bit run;
        bit exp;
        bit warn;
    } exp_t;

    logic clk;
    logic rst_n;
    turn_countdown_if #(.WIDTH(W)) bus ();

    turn_countdown #(.START_SECS(START), .WIDTH(W), .WARN_SECS(WARNS)) dut (
        .C_50Mhz (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   rst_lvl = 1'b0;
    bit   pause_lvl = 1'b0;

    // Reference model: turn phase as a name, remaining seconds as an integer.
    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      m_secs  = START;
    bit      m_prev_tu = 1'b0;

    function automatic exp_t predict();
        exp_t e;
        e.secs = m_secs;
        e.run  = (m_phase == M_RUN);
        e.exp  = (m_phase == M_EXPIRED);
`ifdef TURN_WARN_EN
        e.warn = (m_phase == M_RUN || m_phase == M_PAUSED) && m_secs > 0 && m_secs <= WARNS;
`else
        e.warn = 1'b0;
`endif
        return e;
    endfunction

    task automatic model_edge(input bit s, input bit p, input bit a, input bit tu);
        bit second;
        if (!rst_lvl) begin
            m_phase = M_IDLE; m_secs = START; m_prev_tu = 1'b0;
            return;
        end
        second = tu && !m_prev_tu;
        m_prev_tu = tu;
        if (s) begin
            m_phase = M_RUN; m_secs = START;
        end else begin
            case (m_phase)
                M_RUN: begin
                    if (m_secs == 0) m_phase = M_EXPIRED;
                    else if (p) m_phase = M_PAUSED;
                    else if (second) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) m_phase = M_EXPIRED;
                    end
                end
                M_PAUSED: if (!p) m_phase = M_RUN;
                M_EXPIRED: if (a) begin m_phase = M_IDLE; m_secs = START; end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input bit s, input bit a, input bit tu);
        @(negedge clk);
        rst_n      = rst_lvl;
        bus.start  = s;
        bus.ack    = a;
        bus.timeUp = tu;
        bus.pause  = pause_lvl;
        model_edge(s, pause_lvl, a, tu);
        exp_q.push_back(predict());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic second_pulse(input int hi);
        for (int i = 0; i < hi; i++) cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic compare(input string name, input exp_t e);
        vectors++;
        if (int'(bus.secs_left) != e.secs || int'(bus.tens) != e.secs / 10 ||
            int'(bus.ones) != e.secs % 10 || bus.running !== e.run ||
            bus.expired !== e.exp || bus.warn !== e.warn) begin
            miscompares++;
            $display("FAIL %s t=%0t: got secs=%0d tens=%0d ones=%0d run=%b exp=%b warn=%b, want secs=%0d tens=%0d ones=%0d run=%b exp=%b warn=%b",
                     name, $time, bus.secs_left, bus.tens, bus.ones, bus.running, bus.expired, bus.warn,
                     e.secs, e.secs / 10, e.secs % 10, e.run, e.exp, e.warn);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("cycle_outputs", e);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time budget exceeded, got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int dwell;
        bit tu_lvl;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.ack    = 1'b0;
        bus.timeUp = 1'b0;
        bus.pause  = 1'b0;

        rst_lvl = 1'b0;
        idle_cycles(3);
        rst_lvl = 1'b1;
        idle_cycles(3);

        // Full countdown from START to expiry.
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(2);
        for (int k = 0; k < START; k++) second_pulse(100);

        // Expired: ticks ignored, ack returns to idle, second ack inert.
        second_pulse(10);
        second_pulse(10);
        cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(2);
        cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(2);

        // Pause at 9 swallows ticks; resume then one tick gives 8.
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) second_pulse(20);
        pause_lvl = 1'b1;
        idle_cycles(2);
        for (int k = 0; k < 3; k++) second_pulse(20);
        pause_lvl = 1'b0;
        idle_cycles(2);
        second_pulse(20);

        // Down to 4, then start coinciding with a timeUp rising edge.
        for (int k = 0; k < 4; k++) second_pulse(10);
        cycle(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1);
        idle_cycles(3);

        // Down to 7, then asynchronous reset between clock edges.
        for (int k = 0; k < 8; k++) second_pulse(10);
        @(posedge clk);
        #3;
        rst_n   = 1'b0;
        rst_lvl = 1'b0;
        #1;
        begin
            exp_t r;
            r.secs = START; r.run = 1'b0; r.exp = 1'b0; r.warn = 1'b0;
            compare("async_reset", r);
        end
        m_phase = M_IDLE; m_secs = START; m_prev_tu = 1'b0;
        idle_cycles(3);
        rst_lvl = 1'b1;
        idle_cycles(2);

        // Randomized control traffic.
        tu_lvl = 1'b0;
        dwell  = 1;
        for (int i = 0; i < 4000; i++) begin
            bit s, a;
            dwell--;
            if (dwell <= 0) begin
                tu_lvl = ~tu_lvl;
                dwell  = int'($urandom_range(1, 12));
            end
            if ($urandom_range(0, 39) == 0) pause_lvl = ~pause_lvl;
            s = ($urandom_range(0, 79) == 0);
            a = ($urandom_range(0, 9) == 0);
            rst_lvl = ($urandom_range(0, 999) != 0);
            cycle(s, a, tu_lvl);
        end
        rst_lvl = 1'b1;
        pause_lvl = 1'b0;
        idle_cycles(2);

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
